// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory, decode-side handshake and redirect signals of the fetch stage
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign;
    modport master (
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign,
        input  imem_rdata, stall, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign,
        output imem_rdata, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, synchronous-read imem request tracking and IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        req_valid;
    logic [31:0] target;
    always_comb target = {bus.redirect_pc[31:2], 2'b00};
    // on stall the in-flight address is re-issued so imem_rdata still matches req_pc next cycle
    always_comb bus.imem_addr = rst ? pc : bus.redirect_valid ? target : bus.stall ? req_pc : pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_PC;
            req_pc          <= RESET_PC;
            req_valid       <= 1'b0;
            bus.if_id_pc    <= 32'h0;
            bus.if_id_instr <= NOP_INSTR;
            bus.if_id_valid <= 1'b0;
            bus.misalign    <= 1'b0;
        end else begin
            bus.misalign <= bus.redirect_valid & |bus.redirect_pc[1:0];
            if (bus.redirect_valid) begin
                bus.if_id_valid <= 1'b0;
                bus.if_id_instr <= NOP_INSTR;
                req_pc          <= target;
                req_valid       <= 1'b1;
                pc              <= target + 32'd4;
            end else if (!bus.stall) begin
                bus.if_id_instr <= req_valid ? bus.imem_rdata : NOP_INSTR;
                bus.if_id_pc    <= req_pc;
                bus.if_id_valid <= req_valid;
                req_pc          <= pc;
                req_valid       <= 1'b1;
                pc              <= pc + 32'd4;
            end
        end
    end
endmodule
